// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: register file, destination resolve and ID/EX
// register with load-use bubble insertion behind valid/ready.
module decode_stage_pipe #(
  parameter  int DATA_W   = 16,
  parameter  int INSTR_W  = 16,
  parameter  int NUM_REGS = 8,
  parameter  int RS_LSB   = 8,
  parameter  int RT_LSB   = 5,
  parameter  int RD_LSB   = 2,
  parameter  int LOAD_LAT = 1,
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [INSTR_W-1:0] next_pc_in,
  input  logic [1:0]         reg_dst_in,
  input  logic               wr_en_in,
  input  logic               is_load_in,
  input  logic               uses_rs_in,
  input  logic               uses_rt_in,
  input  logic               wb_en,
  input  logic [AW-1:0]      wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [INSTR_W-1:0] next_pc_out,
  output logic [DATA_W-1:0]  rs_data_out,
  output logic [DATA_W-1:0]  rt_data_out,
  output logic               wr_en_out,
  output logic               is_load_out,
  output logic [AW-1:0]      wr_addr_out,
  output logic               stall,
  output logic               err
);

  localparam int BW   = $clog2(LOAD_LAT + 1);
  localparam int RF_N = 1 << AW;
  localparam logic [AW:0]   NR   = (AW + 1)'(NUM_REGS);
  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);
  localparam logic [BW-1:0] BINI = BW'(LOAD_LAT - 1);

  logic [DATA_W-1:0] rf_q [RF_N];

  logic [AW-1:0]      rs_a;
  logic [AW-1:0]      rt_a;
  logic [AW-1:0]      rd_a;
  logic [AW-1:0]      dst;
  logic [DATA_W-1:0]  rs_rd;
  logic [DATA_W-1:0]  rt_rd;
  logic               wb_ok;
  logic               adv;
  logic               hz;
  logic               xfer;
  logic               bub_nz;

  logic               ov_q, ov_d;
  logic [BW-1:0]      bub_q, bub_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0]  rs_q, rs_d;
  logic [DATA_W-1:0]  rt_q, rt_d;
  logic               wen_q, wen_d;
  logic               ld_q, ld_d;
  logic [AW-1:0]      wa_q, wa_d;
  logic               err_q, err_d;

  assign rs_a  = instr_in[RS_LSB +: AW];
  assign rt_a  = instr_in[RT_LSB +: AW];
  assign rd_a  = instr_in[RD_LSB +: AW];
  assign wb_ok = ({1'b0, wb_addr} < NR);

  // Reads see a writeback landing on the same edge.
  always_comb begin
    rs_rd = rf_q[rs_a];
    rt_rd = rf_q[rt_a];
    if (wb_en && (wb_addr == rs_a)) begin
      rs_rd = wb_data;
    end
    if (wb_en && (wb_addr == rt_a)) begin
      rt_rd = wb_data;
    end
  end

  always_comb begin
    dst = rt_a;
    unique case (reg_dst_in)
      2'd0: dst = rt_a;
      2'd1: dst = rs_a;
      2'd2: dst = rd_a;
      2'd3: dst = LAST;
    endcase
  end

  assign adv    = out_ready | ~ov_q;
  assign bub_nz = (bub_q != '0);
  assign hz     = in_valid & ov_q & ld_q & wen_q &
                  ((uses_rs_in & (rs_a == wa_q)) |
                   (uses_rt_in & (rt_a == wa_q)));
  assign in_ready = rst & adv & ~hz & ~bub_nz & ~flush;
  assign xfer     = in_valid & in_ready;
  assign stall    = hz | bub_nz;

  always_comb begin
    ov_d    = ov_q;
    bub_d   = bub_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    wen_d   = wen_q;
    ld_d    = ld_q;
    wa_d    = wa_q;
    unique case (1'b1)
      flush: begin
        ov_d  = 1'b0;
        bub_d = '0;
      end
      xfer: begin
        ov_d    = 1'b1;
        instr_d = instr_in;
        pc_d    = next_pc_in;
        rs_d    = rs_rd;
        rt_d    = rt_rd;
        wen_d   = wr_en_in;
        ld_d    = is_load_in;
        wa_d    = dst;
      end
      (adv & ~xfer & ~flush): begin
        ov_d = 1'b0;
        if (hz) begin
          bub_d = BINI;
        end else if (bub_nz) begin
          bub_d = bub_q - BW'(1);
        end
      end
      default: begin
        if (bub_nz) begin
          bub_d = bub_q - BW'(1);
        end
      end
    endcase
  end

  assign err_d = err_q | (wb_en & ~wb_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RF_N; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_en && wb_ok) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ov_q    <= 1'b0;
      bub_q   <= '0;
      instr_q <= '0;
      pc_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      wen_q   <= 1'b0;
      ld_q    <= 1'b0;
      wa_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      ov_q    <= ov_d;
      bub_q   <= bub_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      wen_q   <= wen_d;
      ld_q    <= ld_d;
      wa_q    <= wa_d;
      err_q   <= err_d;
    end
  end

  assign out_valid   = ov_q;
  assign instr_out   = instr_q;
  assign next_pc_out = pc_q;
  assign rs_data_out = rs_q;
  assign rt_data_out = rt_q;
  assign wr_en_out   = wen_q;
  assign is_load_out = ld_q;
  assign wr_addr_out = wa_q;
  assign err         = err_q;

endmodule
